// File: rtl/ajcrisc_cu_fsm_if.sv
// Control bundle between the ajcrisc control unit (master) and its datapath (slave).
// Carries decode inputs (IW, flags) and every datapath strobe and select.
interface ajcrisc_cu_fsm_if;
    logic [7:0] IW;
    logic [7:0] PMout;
    logic [3:0] SR_CNVZ;
    logic       RST_PC, LD_PC, CNT_PC, LD_IR;
    logic       LD_R0, LD_R1, LD_R2, LD_R3;
    logic       LD_TXR, LD_TYR, LD_TK;
    logic       LD_SR, LD_MABR, LD_MAXR, LD_MAR, RW, LD_IPDR, LD_OPDR;
    logic [1:0] SRC1_SEL, SRC2_SEL, WB_SEL;
    logic [3:0] ALU_FS;
    logic       HALTED;
    logic [3:0] State;

    modport master (
        input  IW, PMout, SR_CNVZ,
        output RST_PC, LD_PC, CNT_PC, LD_IR, LD_R0, LD_R1, LD_R2, LD_R3,
               LD_TXR, LD_TYR, LD_TK, LD_SR, LD_MABR, LD_MAXR, LD_MAR, RW,
               LD_IPDR, LD_OPDR, SRC1_SEL, SRC2_SEL, WB_SEL, ALU_FS, HALTED, State
    );

    modport slave (
        output IW, PMout, SR_CNVZ,
        input  RST_PC, LD_PC, CNT_PC, LD_IR, LD_R0, LD_R1, LD_R2, LD_R3,
               LD_TXR, LD_TYR, LD_TK, LD_SR, LD_MABR, LD_MAXR, LD_MAR, RW,
               LD_IPDR, LD_OPDR, SRC1_SEL, SRC2_SEL, WB_SEL, ALU_FS, HALTED, State
    );
endinterface

// File: rtl/ajcrisc_cu_fsm.sv
// Multicycle fetch/decode/execute control unit for the 8-bit ajcrisc datapath.
// Moore outputs decoded from the current state and the latched instruction word.
module ajcrisc_cu_fsm (
    input  logic              Clock,
    input  logic              Reset,
    ajcrisc_cu_fsm_if.master  bus
);
    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_IN_WB    = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_ACC  = 4'd5,
        S_LD_WB    = 4'd6,
        S_BR_ADDR  = 4'd7,
        S_BR_LD    = 4'd8,
        S_HALT     = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] opcode;
    logic [1:0] ri, rj;
    logic       br_taken;
    logic       flag_c, flag_n, flag_v, flag_z;
    logic       pmout_unused;

    logic       rst_pc, ld_pc, cnt_pc, ld_ir;
    logic [3:0] ld_r;
    logic       ld_sr, ld_mabr, ld_maxr, ld_mar, rw, ld_ipdr, ld_opdr, halted;
    logic [1:0] src1_sel, src2_sel, wb_sel;
    logic [3:0] alu_fs;

    assign opcode = bus.IW[7:4];
    assign ri     = bus.IW[3:2];
    assign rj     = bus.IW[1:0];
    assign {flag_c, flag_n, flag_v, flag_z} = bus.SR_CNVZ;
    assign pmout_unused = ^bus.PMout;

    // Branch condition lives in IW[3:0]; codes above 7 never branch.
    always_comb begin
        br_taken = 1'b0;
        case (bus.IW[3:0])
            4'h0:    br_taken = 1'b1;
            4'h1:    br_taken = flag_c;
            4'h2:    br_taken = ~flag_c;
            4'h3:    br_taken = flag_z;
            4'h4:    br_taken = ~flag_z;
            4'h5:    br_taken = flag_n;
            4'h6:    br_taken = ~flag_n;
            4'h7:    br_taken = flag_v;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= S_RST;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        rst_pc   = 1'b0;
        ld_pc    = 1'b0;
        cnt_pc   = 1'b0;
        ld_ir    = 1'b0;
        ld_r     = 4'b0000;
        ld_sr    = 1'b0;
        ld_mabr  = 1'b0;
        ld_maxr  = 1'b0;
        ld_mar   = 1'b0;
        rw       = 1'b0;
        ld_ipdr  = 1'b0;
        ld_opdr  = 1'b0;
        halted   = 1'b0;
        src1_sel = 2'd0;
        src2_sel = 2'd0;
        wb_sel   = 2'd0;
        alu_fs   = 4'd0;
        case (state_q)
            S_RST: begin
                rst_pc  = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ld_ir   = 1'b1;
                cnt_pc  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    4'hA: begin
                        ld_ipdr = 1'b1;
                        state_d = S_IN_WB;
                    end
                    4'hB: begin
                        src1_sel = ri;
                        ld_opdr  = 1'b1;
                        state_d  = S_FETCH;
                    end
                    4'hC, 4'hE: begin
                        // Address word sits at PC; Rj supplies the index.
                        ld_mabr  = 1'b1;
                        ld_maxr  = 1'b1;
                        src1_sel = rj;
                        cnt_pc   = 1'b1;
                        state_d  = S_MEM_ADDR;
                    end
                    4'hD: begin
                        cnt_pc = 1'b1;
                        if (br_taken) begin
                            ld_mabr = 1'b1;
                            ld_maxr = 1'b1;
                            state_d = S_BR_ADDR;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                    4'hF: state_d = S_HALT;
                    default: begin
                        alu_fs   = opcode;
                        src1_sel = ri;
                        src2_sel = rj;
                        wb_sel   = 2'd0;
                        ld_r[ri] = 1'b1;
                        ld_sr    = 1'b1;
                        state_d  = S_FETCH;
                    end
                endcase
            end
            S_IN_WB: begin
                wb_sel   = 2'd2;
                ld_r[ri] = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_ADDR: begin
                ld_mar  = 1'b1;
                state_d = S_MEM_ACC;
            end
            S_MEM_ACC: begin
                if (opcode == 4'hE) begin
                    src1_sel = ri;
                    rw       = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    // Data memory read settles on the falling edge; write back next cycle.
                    state_d = S_LD_WB;
                end
            end
            S_LD_WB: begin
                wb_sel   = 2'd1;
                ld_r[ri] = 1'b1;
                state_d  = S_FETCH;
            end
            S_BR_ADDR: begin
                ld_mar  = 1'b1;
                state_d = S_BR_LD;
            end
            S_BR_LD: begin
                ld_pc   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_RST;
        endcase
    end

    assign bus.RST_PC   = Reset | rst_pc;
    assign bus.LD_PC    = ld_pc;
    assign bus.CNT_PC   = cnt_pc;
    assign bus.LD_IR    = ld_ir;
    assign bus.LD_R0    = ld_r[0];
    assign bus.LD_R1    = ld_r[1];
    assign bus.LD_R2    = ld_r[2];
    assign bus.LD_R3    = ld_r[3];
    assign bus.LD_TXR   = 1'b0;
    assign bus.LD_TYR   = 1'b0;
    assign bus.LD_TK    = 1'b0;
    assign bus.LD_SR    = ld_sr;
    assign bus.LD_MABR  = ld_mabr;
    assign bus.LD_MAXR  = ld_maxr;
    assign bus.LD_MAR   = ld_mar;
    assign bus.RW       = rw;
    assign bus.LD_IPDR  = ld_ipdr;
    assign bus.LD_OPDR  = ld_opdr;
    assign bus.SRC1_SEL = src1_sel;
    assign bus.SRC2_SEL = src2_sel;
    assign bus.WB_SEL   = wb_sel;
    assign bus.ALU_FS   = alu_fs;
    assign bus.HALTED   = halted;
    assign bus.State    = state_q;
endmodule

// File: tb/tb_ajcrisc_cu_fsm.sv
// Scoreboard bench for ajcrisc_cu_fsm: per-instruction cycle plans built from the ISA
// timing rules are queued by the stimulus and compared cycle by cycle by a monitor.
module tb_ajcrisc_cu_fsm;
    typedef struct packed {
        logic [3:0] st;
        logic       rst_pc, ld_pc, cnt_pc, ld_ir;
        logic [3:0] ld_r;
        logic       ld_sr, ld_mabr, ld_maxr, ld_mar, rw, ld_ipdr, ld_opdr, res;
        logic [1:0] s1, s2, wb;
        logic [3:0] fs;
        logic       halted;
    } ov_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    bit    mon_en = 1'b0;
    int    n_chk = 0;
    int    n_fail = 0;
    ov_t   sbq[$];
    string tagq[$];
    ov_t   plan[$];

    ajcrisc_cu_fsm_if bus();
    ajcrisc_cu_fsm dut (.Clock(clk), .Reset(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic ov_t blank(input logic [3:0] st);
        ov_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic bit taken(input logic [3:0] cond, input logic [3:0] sr);
        bit c, n, v, z;
        {c, n, v, z} = sr;
        case (cond)
            4'd0: return 1'b1;
            4'd1: return c;
            4'd2: return !c;
            4'd3: return z;
            4'd4: return !z;
            4'd5: return n;
            4'd6: return !n;
            4'd7: return v;
            default: return 1'b0;
        endcase
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, starting at its fetch.
    task automatic make_plan(input logic [7:0] iw, input logic [3:0] sr, input int halt_n);
        ov_t o, d;
        logic [3:0] op;
        logic [1:0] ri, rj;
        op = iw[7:4]; ri = iw[3:2]; rj = iw[1:0];
        plan.delete();
        o = blank(4'd1); o.ld_ir = 1; o.cnt_pc = 1; plan.push_back(o);
        d = blank(4'd2);
        if (op <= 4'h9) begin
            d.fs = op; d.s1 = ri; d.s2 = rj; d.ld_r[ri] = 1; d.ld_sr = 1;
            plan.push_back(d);
        end else if (op == 4'hA) begin
            d.ld_ipdr = 1; plan.push_back(d);
            o = blank(4'd3); o.wb = 2; o.ld_r[ri] = 1; plan.push_back(o);
        end else if (op == 4'hB) begin
            d.s1 = ri; d.ld_opdr = 1; plan.push_back(d);
        end else if (op == 4'hC || op == 4'hE) begin
            d.ld_mabr = 1; d.ld_maxr = 1; d.s1 = rj; d.cnt_pc = 1; plan.push_back(d);
            o = blank(4'd4); o.ld_mar = 1; plan.push_back(o);
            o = blank(4'd5);
            if (op == 4'hE) begin
                o.s1 = ri; o.rw = 1; plan.push_back(o);
            end else begin
                plan.push_back(o);
                o = blank(4'd6); o.wb = 1; o.ld_r[ri] = 1; plan.push_back(o);
            end
        end else if (op == 4'hD) begin
            d.cnt_pc = 1;
            if (taken(iw[3:0], sr)) begin
                d.ld_mabr = 1; d.ld_maxr = 1; plan.push_back(d);
                o = blank(4'd7); o.ld_mar = 1; plan.push_back(o);
                o = blank(4'd8); o.ld_pc = 1; plan.push_back(o);
            end else begin
                plan.push_back(d);
            end
        end else begin
            plan.push_back(d);
            for (int i = 0; i < halt_n; i++) begin
                o = blank(4'd9); o.halted = 1; plan.push_back(o);
            end
        end
    endtask

    // Called in a fetch cycle (just after the edge); keep<0 runs the whole instruction.
    task automatic run(input string name, input logic [7:0] iw, input logic [3:0] sr,
                       input int halt_n, input int keep);
        int n;
        bus.IW = iw;
        bus.SR_CNVZ = sr;
        bus.PMout = 8'($urandom);
        make_plan(iw, sr, halt_n);
        n = (keep < 0 || keep > plan.size()) ? plan.size() : keep;
        for (int i = 0; i < n; i++) begin
            sbq.push_back(plan[i]);
            tagq.push_back($sformatf("%s iw=%h cyc%0d", name, iw, i));
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int hold);
        ov_t o;
        rst = 1'b1;
        o = blank(4'd0); o.rst_pc = 1;
        for (int i = 0; i <= hold; i++) begin
            sbq.push_back(o);
            tagq.push_back($sformatf("reset cyc%0d", i));
        end
        repeat (hold) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        ov_t a, e;
        string t;
        if (mon_en) begin
            a = '0;
            a.st = bus.State;
            a.rst_pc = bus.RST_PC; a.ld_pc = bus.LD_PC; a.cnt_pc = bus.CNT_PC; a.ld_ir = bus.LD_IR;
            a.ld_r = {bus.LD_R3, bus.LD_R2, bus.LD_R1, bus.LD_R0};
            a.ld_sr = bus.LD_SR; a.ld_mabr = bus.LD_MABR; a.ld_maxr = bus.LD_MAXR;
            a.ld_mar = bus.LD_MAR; a.rw = bus.RW; a.ld_ipdr = bus.LD_IPDR; a.ld_opdr = bus.LD_OPDR;
            a.res = bus.LD_TXR | bus.LD_TYR | bus.LD_TK;
            a.s1 = bus.SRC1_SEL; a.s2 = bus.SRC2_SEL; a.wb = bus.WB_SEL;
            a.fs = bus.ALU_FS; a.halted = bus.HALTED;
            n_chk++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL underflow: DUT output %h with no expectation queued", a);
            end else begin
                e = sbq.pop_front();
                t = tagq.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %h want %h", t, a, e);
                end
            end
            n_chk++;
            if ($countones(a.ld_r) > 1 || (a.ld_pc && a.cnt_pc)) begin
                n_fail++;
                $display("FAIL invariant: ld_r=%b ld_pc=%b cnt_pc=%b", a.ld_r, a.ld_pc, a.cnt_pc);
            end
        end
    end

    initial begin
        logic [7:0] iw;
        int keep;
        bus.IW = 8'h00; bus.PMout = 8'h00; bus.SR_CNVZ = 4'h0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        do_reset(2);

        run("alu36", 8'h36, 4'($urandom), 0, -1);
        run("st_e9", 8'hE9, 4'($urandom), 0, -1);
        run("ld_c7", 8'hC7, 4'($urandom), 0, -1);
        run("br_taken", 8'hD3, 4'b0001, 0, -1);
        run("br_not", 8'hD3, 4'b0000, 0, -1);
        run("in_a4", 8'hA4, 4'h0, 0, -1);
        run("out_b8", 8'hB8, 4'h0, 0, -1);
        run("ld_abort", 8'hC7, 4'h0, 0, 4);
        do_reset(1);
        run("halt", 8'hF0, 4'h0, 20, -1);
        do_reset(2);

        for (int k = 0; k < 400; k++) begin
            iw = 8'($urandom);
            keep = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 3)) : -1;
            if (iw[7:4] == 4'hF) begin
                run("rnd_halt", iw, 4'($urandom), int'($urandom_range(1, 5)), -1);
                do_reset(1);
            end else begin
                run("rnd", iw, 4'($urandom), 0, keep);
                if (keep > 0) do_reset(1);
            end
        end

        mon_en = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
